// File: rtl/irda_mir_rx_ctrl_pkg.sv
// Shared definitions for the MIR receive framing controller: state encodings,
// destuffing thresholds and CRC-CCITT constants.
package irda_mir_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_FLAG = 2'd2,
    ST_DATA = 2'd3
  } rx_state_e;

  localparam logic [2:0]  ABORT_ONES  = 3'd7;
  localparam logic [2:0]  STUFF_ONES  = 3'd5;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'hF0B8;
  localparam logic [15:0] CRC_POLY    = 16'h8408;  // 0x1021 bit-reversed

  // One LSB-first step of the reflected CRC-CCITT.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/irda_mir_crc16.sv
// Serial 16-bit CRC-CCITT (reflected). crc_next is the value including the
// bit presented this cycle, so a closing flag on the same strobe sees it.
module irda_mir_crc16
  import irda_mir_rx_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc_next
);

  logic [15:0] crc_q;
  logic [15:0] base;

  always_comb begin
    base     = init ? CRC_INIT : crc_q;
    crc_next = en ? crc16_step(base, din) : base;
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) crc_q <= CRC_INIT;
    else          crc_q <= crc_next;
  end

endmodule

// File: rtl/irda_mir_rx_ctrl.sv
// MIR receive framing controller: flag sequencing, HDLC destuffing and
// LSB-first byte assembly. Define IRDA_MIR_RX_CRC_EN to add the FCS check.
module irda_mir_rx_ctrl
  import irda_mir_rx_ctrl_pkg::*;
#(
  parameter int MAX_BYTES = 2051,
  parameter int MIN_BYTES = 3,
  parameter int BCNT_W    = 12
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       mir_rx_en,
  input  logic       mir_rxbit_enable,
  input  logic       std_st_detected,
  input  logic       std_is_good_bit,
  input  logic       std_o,
  output logic       std_restart,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       abort_o,
  output logic       frame_err_o,
  output logic       rx_busy_o,
  output logic       crc_err_o,
  output logic [1:0] rx_state_o
);

  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BYTES);
  localparam logic [BCNT_W-1:0] SAT_CNT = BCNT_W'(MAX_BYTES + 1);
  localparam logic [BCNT_W-1:0] MIN_CNT = BCNT_W'(MIN_BYTES);

  rx_state_e         state_q, state_n;
  logic [2:0]        ones_q, ones_n, ones_inc;
  logic [2:0]        bit_q, bit_n;
  logic [BCNT_W-1:0] bcnt_q, bcnt_n;
  logic [7:0]        sh_q, sh_n, byte_n;
  logic              restart_n, start_n, end_n, abort_n, err_n, valid_n;
  logic              append, terminated;

  assign ones_inc   = ones_q + 3'd1;
  assign rx_state_o = state_q;

  always_comb begin
    state_n    = state_q;
    ones_n     = ones_q;
    bit_n      = bit_q;
    bcnt_n     = bcnt_q;
    sh_n       = sh_q;
    byte_n     = byte_o;
    restart_n  = 1'b0;
    start_n    = 1'b0;
    end_n      = 1'b0;
    abort_n    = 1'b0;
    err_n      = 1'b0;
    valid_n    = 1'b0;
    append     = 1'b0;
    terminated = 1'b0;

    if (!mir_rx_en) begin
      state_n   = ST_IDLE;
      ones_n    = '0;
      bit_n     = '0;
      bcnt_n    = '0;
      restart_n = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: state_n = ST_HUNT;
        ST_HUNT: begin
          if (mir_rxbit_enable && std_st_detected) begin
            state_n = ST_FLAG;
            ones_n  = '0;
            bit_n   = '0;
            bcnt_n  = '0;
          end
        end
        default: begin
          if (mir_rxbit_enable) begin
            // The data bit is handled first; a flag on the same strobe then
            // sees the updated counts.
            if (std_is_good_bit) begin
              if (state_q == ST_FLAG) begin
                start_n = 1'b1;
                state_n = ST_DATA;
              end
              if (std_o) begin
                if (ones_inc == ABORT_ONES) begin
                  abort_n    = 1'b1;
                  restart_n  = 1'b1;
                  state_n    = ST_HUNT;
                  ones_n     = '0;
                  bit_n      = '0;
                  bcnt_n     = '0;
                  terminated = 1'b1;
                end else begin
                  ones_n = ones_inc;
                  append = 1'b1;
                end
              end else begin
                ones_n = '0;
                append = (ones_q != STUFF_ONES);
              end
              if (append) begin
                sh_n  = {std_o, sh_q[7:1]};
                bit_n = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                  valid_n = 1'b1;
                  byte_n  = sh_n;
                  if (bcnt_q == MAX_CNT) begin
                    err_n      = 1'b1;
                    restart_n  = 1'b1;
                    state_n    = ST_HUNT;
                    ones_n     = '0;
                    bit_n      = '0;
                    bcnt_n     = '0;
                    terminated = 1'b1;
                  end else if (bcnt_q != SAT_CNT) begin
                    bcnt_n = bcnt_q + 1'b1;
                  end
                end
              end
            end
            // A closing flag doubles as the opening flag of the next frame.
            if (std_st_detected && !terminated) begin
              if (state_n == ST_DATA) begin
                if (bit_n == 3'd0 && bcnt_n >= MIN_CNT) end_n = 1'b1;
                else                                    err_n = 1'b1;
              end
              state_n = ST_FLAG;
              ones_n  = '0;
              bit_n   = '0;
              bcnt_n  = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      ones_q        <= '0;
      bit_q         <= '0;
      bcnt_q        <= '0;
      sh_q          <= '0;
      byte_o        <= '0;
      std_restart   <= 1'b1;
      byte_valid_o  <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      abort_o       <= 1'b0;
      frame_err_o   <= 1'b0;
      rx_busy_o     <= 1'b0;
    end else begin
      state_q       <= state_n;
      ones_q        <= ones_n;
      bit_q         <= bit_n;
      bcnt_q        <= bcnt_n;
      sh_q          <= sh_n;
      byte_o        <= byte_n;
      std_restart   <= restart_n;
      byte_valid_o  <= valid_n;
      frame_start_o <= start_n;
      frame_end_o   <= end_n;
      abort_o       <= abort_n;
      frame_err_o   <= err_n;
      rx_busy_o     <= (state_n == ST_DATA);
    end
  end

`ifdef IRDA_MIR_RX_CRC_EN
  logic        crc_init;
  logic [15:0] crc_next;

  assign crc_init = mir_rx_en && (state_q == ST_FLAG) && mir_rxbit_enable && std_is_good_bit;

  irda_mir_crc16 u_crc (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .init     (crc_init),
    .en       (append),
    .din      (std_o),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk) begin
    if (wb_rst_i) crc_err_o <= 1'b0;
    else          crc_err_o <= end_n && (crc_next != CRC_RESIDUE);
  end
`else
  assign crc_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_irda_mir_rx_ctrl.sv
// Bench for irda_mir_rx_ctrl: vector table, directed frame sequences and
// random bit streams checked cycle by cycle against a bit-queue model.
module tb_irda_mir_rx_ctrl;
  import irda_mir_rx_ctrl_pkg::*;

  localparam int MAX_BYTES = 2051;
  localparam int MIN_BYTES = 3;

  logic clk = 1'b0;
  logic wb_rst_i, mir_rx_en, mir_rxbit_enable, std_st_detected, std_is_good_bit, std_o;
  logic std_restart, byte_valid_o, frame_start_o, frame_end_o, abort_o, frame_err_o;
  logic rx_busy_o, crc_err_o;
  logic [7:0] byte_o;
  logic [1:0] rx_state_o;

  always #5 clk = ~clk;

  irda_mir_rx_ctrl #(.MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES), .BCNT_W(12)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .mir_rx_en(mir_rx_en),
    .mir_rxbit_enable(mir_rxbit_enable), .std_st_detected(std_st_detected),
    .std_is_good_bit(std_is_good_bit), .std_o(std_o), .std_restart(std_restart),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .frame_start_o(frame_start_o),
    .frame_end_o(frame_end_o), .abort_o(abort_o), .frame_err_o(frame_err_o),
    .rx_busy_o(rx_busy_o), .crc_err_o(crc_err_o), .rx_state_o(rx_state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  bit sb_on = 0;
  int got_valid, got_start, got_end, got_abort, got_err, got_crcerr, got_restart_hi, got_end_byte;
  int tx_ones = 0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_HUNT = 1, M_FLAG = 2, M_DATA = 3;
  int m_mode, m_ones, m_nbytes;
  bit m_bits[$];
  logic [7:0] m_byte;
  logic [15:0] m_crc;
  logic m_restart, m_start, m_end, m_abort, m_err, m_valid, m_busy, m_crcerr;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    c  = c >> 1;
    if (fb) c = c ^ 16'h8408;
    return c;
  endfunction

  task automatic model_clear();
    m_ones = 0; m_nbytes = 0; m_bits.delete();
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; model_clear();
    m_byte = 8'h00; m_crc = 16'hFFFF;
    m_restart = 1; m_start = 0; m_end = 0; m_abort = 0; m_err = 0; m_valid = 0;
    m_busy = 0; m_crcerr = 0;
  endtask

  task automatic model_step(input logic en, stb, flg, good, b);
    bit done, keep;
    logic [7:0] v;
    m_restart = 0; m_start = 0; m_end = 0; m_abort = 0; m_err = 0; m_valid = 0; m_crcerr = 0;
    done = 0;
    if (!en) begin
      m_mode = M_IDLE; model_clear(); m_restart = 1;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_HUNT;
    end else if (m_mode == M_HUNT) begin
      if (stb && flg) begin m_mode = M_FLAG; model_clear(); end
    end else if (stb) begin
      if (good) begin
        if (m_mode == M_FLAG) begin m_start = 1; m_mode = M_DATA; m_crc = 16'hFFFF; end
        keep = 1;
        if (b) begin
          m_ones++;
          if (m_ones >= 7) begin
            m_abort = 1; m_restart = 1; m_mode = M_HUNT; model_clear(); done = 1; keep = 0;
          end
        end else begin
          if (m_ones == 5) keep = 0;
          m_ones = 0;
        end
        if (keep) begin
          m_bits.push_back(b);
          m_crc = crc_upd(m_crc, b);
          if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) v[i] = m_bits[i];
            m_byte = v; m_valid = 1; m_bits.delete();
            if (m_nbytes == MAX_BYTES) begin
              m_err = 1; m_restart = 1; m_mode = M_HUNT; model_clear(); done = 1;
            end else m_nbytes++;
          end
        end
      end
      if (flg && !done) begin
        if (m_mode == M_DATA) begin
          if (m_bits.size() == 0 && m_nbytes >= MIN_BYTES) begin
            m_end = 1;
`ifdef IRDA_MIR_RX_CRC_EN
            m_crcerr = (m_crc != 16'hF0B8);
`endif
          end else m_err = 1;
        end
        m_mode = M_FLAG; model_clear();
      end
    end
    m_busy = (m_mode == M_DATA);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    got_valid = 0; got_start = 0; got_end = 0; got_abort = 0; got_err = 0;
    got_crcerr = 0; got_restart_hi = 0; got_end_byte = 0;
  endtask

  task automatic tick(input logic en, stb, flg, good, b);
    mir_rx_en = en; mir_rxbit_enable = stb; std_st_detected = flg;
    std_is_good_bit = good; std_o = b;
    model_step(en, stb, flg, good, b);
    @(posedge clk);
    #1;
    check("outputs",
          {16'h0, std_restart, frame_start_o, frame_end_o, abort_o, frame_err_o,
           byte_valid_o, rx_busy_o, crc_err_o, byte_o},
          {16'h0, m_restart, m_start, m_end, m_abort, m_err, m_valid, m_busy, m_crcerr, m_byte});
    if (byte_valid_o) begin
      got_valid++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL byte_unexpected: actual=%0h required=none", byte_o);
        end else check("byte", {24'h0, byte_o}, {24'h0, exp_q.pop_front()});
      end
    end
    got_start      += int'(frame_start_o);
    got_end        += int'(frame_end_o);
    got_abort      += int'(abort_o);
    got_err        += int'(frame_err_o);
    got_crcerr     += int'(crc_err_o);
    got_restart_hi += int'(std_restart);
    if (frame_end_o && byte_valid_o) got_end_byte++;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask
  task automatic start_rx();
    tick(1, 0, 0, 0, 0);
  endtask
  task automatic send_flag();
    tick(1, 1, 1, 0, 0); tx_ones = 0;
  endtask
  task automatic send_raw(input logic b);
    tick(1, 1, 0, 1, b);
  endtask
  task automatic send_data_bit(input logic b, input logic with_flag);
    tick(1, 1, with_flag, 1, b);
    if (with_flag) tx_ones = 0;
    else if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin send_raw(1'b0); tx_ones = 0; end
    end else tx_ones = 0;
  endtask
  task automatic send_byte(input logic [7:0] v, input logic last_flag);
    for (int i = 0; i < 8; i++) send_data_bit(v[i], last_flag && (i == 7));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en, stb, flg, good, b;
    logic [6:0] exp;  // restart, start, end, abort, err, valid, busy
  } vec_t;
  vec_t vecs[13];

  function automatic vec_t mk(input logic en, stb, flg, good, b, input logic [6:0] e);
    vec_t r;
    r.en = en; r.stb = stb; r.flg = flg; r.good = good; r.b = b; r.exp = e;
    return r;
  endfunction

  initial begin
    logic [15:0] crc;
    logic [15:0] fcs;
    logic [7:0] rb;
    int nb;

    vecs[0]  = mk(0, 0, 0, 0, 0, 7'b1000000);
    vecs[1]  = mk(1, 0, 0, 0, 0, 7'b0000000);
    vecs[2]  = mk(1, 0, 0, 0, 0, 7'b0000000);
    vecs[3]  = mk(1, 1, 0, 1, 1, 7'b0000000);  // good bit in HUNT ignored
    vecs[4]  = mk(1, 1, 1, 0, 0, 7'b0000000);
    vecs[5]  = mk(1, 1, 1, 0, 0, 7'b0000000);
    vecs[6]  = mk(1, 1, 0, 1, 0, 7'b0100001);
    vecs[7]  = mk(0, 0, 0, 0, 0, 7'b1000000);  // disable drops frame silently
    vecs[8]  = mk(1, 1, 1, 0, 0, 7'b0000000);  // flag while leaving IDLE ignored
    vecs[9]  = mk(1, 1, 1, 0, 0, 7'b0000000);
    vecs[10] = mk(1, 1, 1, 1, 1, 7'b0100100);  // bit+flag: start then misaligned end
    vecs[11] = mk(1, 1, 0, 1, 1, 7'b0100001);
    vecs[12] = mk(0, 0, 0, 0, 0, 7'b1000000);

    wb_rst_i = 1; mir_rx_en = 0; mir_rxbit_enable = 0; std_st_detected = 0;
    std_is_good_bit = 0; std_o = 0;
    model_reset(); clr_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_restart", {31'h0, std_restart}, 32'h1);
    check("reset_pulses", {26'h0, byte_valid_o, frame_start_o, frame_end_o, abort_o, frame_err_o, crc_err_o}, 32'h0);
    check("reset_busy_byte", {23'h0, rx_busy_o, byte_o}, 32'h0);
    check("reset_state", {30'h0, rx_state_o}, {30'h0, ST_IDLE});
    wb_rst_i = 0;

    // Table: enable/restart timing, HUNT/FLAG behaviour, disable.
    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].en, vecs[i].stb, vecs[i].flg, vecs[i].good, vecs[i].b);
      check($sformatf("vec%0d", i),
            {25'h0, std_restart, frame_start_o, frame_end_o, abort_o, frame_err_o, byte_valid_o, rx_busy_o},
            {25'h0, vecs[i].exp});
    end

    // Basic frame, closing flag on the last data bit.
    sb_on = 1; start_rx(); clr_counts();
    send_flag();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 1); idle(2);
    check("f1_valid", got_valid, 3);
    check("f1_start", got_start, 1);
    check("f1_end", got_end, 1);
    check("f1_end_with_byte", got_end_byte, 1);
    check("f1_err", got_err, 0);

    // Zero-stuffed data.
    clr_counts();
    exp_q.push_back(8'h1F); exp_q.push_back(8'h1F); exp_q.push_back(8'h00);
    send_flag(); send_byte(8'h1F, 0); send_byte(8'h1F, 0); send_byte(8'h00, 0); send_flag(); idle(1);
    check("stuff_valid", got_valid, 3);
    check("stuff_end", got_end, 1);
    check("stuff_err", got_err, 0);

    // Misaligned frame (13 bits) then a good frame.
    clr_counts();
    exp_q.push_back(8'h5A);
    send_flag(); send_byte(8'h5A, 0);
    send_data_bit(1, 0); send_data_bit(0, 0); send_data_bit(1, 0); send_data_bit(0, 0); send_data_bit(1, 0);
    send_flag(); idle(1);
    check("mis_valid", got_valid, 1);
    check("mis_err", got_err, 1);
    check("mis_end", got_end, 0);
    check("mis_state", {30'h0, rx_state_o}, {30'h0, ST_FLAG});
    clr_counts();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_flag(); idle(1);
    check("after_mis_end", got_end, 1);
    check("after_mis_err", got_err, 0);
    check("after_mis_valid", got_valid, 3);

    // Abort: 0xAA then eight raw ones.
    clr_counts();
    exp_q.push_back(8'hAA);
    send_flag(); send_byte(8'hAA, 0);
    for (int i = 0; i < 8; i++) send_raw(1'b1);
    idle(1);
    check("abort_count", got_abort, 1);
    check("abort_restart_pulse", got_restart_hi, 1);
    check("abort_state", {30'h0, rx_state_o}, {30'h0, ST_HUNT});
    check("abort_valid", got_valid, 1);
    check("abort_end_err", got_end + got_err, 0);
    clr_counts();
    for (int i = 0; i < 12; i++) send_raw(i[0]);
    check("hunt_ignores_bits", got_start + got_valid, 0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_flag(); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_flag(); idle(1);
    check("post_abort_start", got_start, 1);
    check("post_abort_end", got_end, 1);

    // Minimum length boundary.
    clr_counts();
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_flag(); idle(1);
    check("short_err", got_err, 1);
    check("short_end", got_end, 0);
    clr_counts();
    exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0); send_flag(); idle(1);
    check("min_end", got_end, 1);
    check("min_err", got_err, 0);

    // Overlong frame: MAX_BYTES+1 bytes.
    clr_counts();
    for (int i = 0; i <= MAX_BYTES; i++) begin
      exp_q.push_back(8'h00); send_byte(8'h00, 0);
    end
    idle(1);
    check("long_valid", got_valid, MAX_BYTES + 1);
    check("long_err", got_err, 1);
    check("long_end", got_end, 0);
    check("long_state", {30'h0, rx_state_o}, {30'h0, ST_HUNT});
    check("exp_q_drained", exp_q.size(), 0);
    sb_on = 0;

`ifdef IRDA_MIR_RX_CRC_EN
    for (int pass = 0; pass < 2; pass++) begin
      crc = 16'hFFFF;
      rb = 8'h01; for (int i = 0; i < 8; i++) crc = crc_upd(crc, rb[i]);
      rb = 8'h02; for (int i = 0; i < 8; i++) crc = crc_upd(crc, rb[i]);
      fcs = ~crc;
      if (pass == 1) fcs = fcs ^ 16'h0010;
      clr_counts();
      send_flag();
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(fcs[7:0], 0); send_byte(fcs[15:8], 0);
      send_flag(); idle(1);
      check($sformatf("crc_end%0d", pass), got_end, 1);
      check($sformatf("crc_err%0d", pass), got_crcerr, pass);
    end
`endif

    // Random raw bit streams (ones-heavy to exercise stuffing and aborts).
    for (int i = 0; i < 4000; i++)
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) < ((i < 2000) ? 7 : 5)));

    // Random well-formed frames.
    tick(0, 0, 0, 0, 0); start_rx(); send_flag();
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        rb = 8'($urandom_range(0, 255));
        send_byte(rb, 0);
        idle($urandom_range(0, 2));
      end
      send_flag();
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
